// File: rtl/frame_ser_pkg.sv
// Shared types and helpers for the frame serializer: FSM state encoding,
// parity mode constants and the parity-bit helper.
package frame_ser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  localparam int PAR_NONE   = 0;
  localparam int PAR_EVEN   = 1;
  localparam int PAR_ODD    = 2;

  // Widest supported data word; narrower words are zero-extended, which
  // leaves their parity unchanged.
  localparam int MAX_DATA_W = 16;

  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input int mode);
    logic r;
    r = 1'b0;
    if (mode == PAR_EVEN) r = ^data;
    else if (mode == PAR_ODD) r = ~(^data);
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Occupancy is tracked by a push/pop counter so full and
// empty never depend on pointer comparison; pointers wrap modulo DEPTH.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     srclk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge srclk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy counter; a simultaneous push and pop keeps level.
  always_ff @(posedge srclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// Word-to-UART-frame serializer: FIFO front end, then start bit, DATA_W data
// bits, optional parity and STOP_BITS stop bits, all paced by bit_tick.
//
//   state | meaning
//   IDLE  | line high, waiting for a ticked cycle with a queued word
//   START | start bit (0) on the line
//   DATA  | data bits, one per tick, LSB or MSB first
//   PAR   | parity bit (only when PARITY != none)
//   STOP  | stop bits (1); last one may chain straight into the next START
module frame_serializer
  import frame_ser_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic                   srclk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  input  logic                   bit_tick,
  output logic                   tx_out,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int BCW = $clog2(DATA_W + 1);

  state_t                state, state_nxt;
  logic [DATA_W-1:0]     shreg, shreg_nxt;
  logic [BCW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [1:0]            stop_cnt, stop_cnt_nxt;
  logic                  par_q, par_nxt;
  logic                  tx_q, tx_nxt;

  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_W-1:0]     head;
  logic [MAX_DATA_W-1:0] head_ext;
  logic                  ser_bit;
  logic [DATA_W-1:0]     shreg_shifted;
  logic                  load;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .srclk     (srclk),
    .reset     (reset),
    .push      (in_valid && in_ready),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE);
  assign tx_out   = tx_q;

  assign ser_bit       = (MSB_FIRST != 0) ? shreg[DATA_W-1] : shreg[0];
  assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[DATA_W-2:0], 1'b0}
                                          : {1'b0, shreg[DATA_W-1:1]};

  // A new frame starts from IDLE, or directly off the final stop bit so that
  // queued words go out with no idle gap.
  assign load = bit_tick && !fifo_empty &&
                ((state == IDLE) || ((state == STOP) && (stop_cnt == '0)));

  // Zero-extend the head word for the shared parity helper.
  always_comb begin
    head_ext             = '0;
    head_ext[DATA_W-1:0] = head;
  end

  // Next-state and datapath: everything holds unless bit_tick is high.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    par_nxt      = par_q;
    tx_nxt       = tx_q;
    fifo_pop     = 1'b0;

    if (bit_tick) begin
      case (state)
        IDLE: begin
          tx_nxt = 1'b1;
        end
        START: begin
          state_nxt   = DATA;
          tx_nxt      = ser_bit;
          shreg_nxt   = shreg_shifted;
          bit_cnt_nxt = BCW'(1);
        end
        DATA: begin
          if (bit_cnt == BCW'(DATA_W)) begin
            bit_cnt_nxt = '0;
            if (PARITY != PAR_NONE) begin
              state_nxt = PAR;
              tx_nxt    = par_q;
            end else begin
              state_nxt    = STOP;
              tx_nxt       = 1'b1;
              stop_cnt_nxt = 2'(STOP_BITS - 1);
            end
          end else begin
            tx_nxt      = ser_bit;
            shreg_nxt   = shreg_shifted;
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
        PAR: begin
          state_nxt    = STOP;
          tx_nxt       = 1'b1;
          stop_cnt_nxt = 2'(STOP_BITS - 1);
        end
        STOP: begin
          if (stop_cnt == '0) begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end else begin
            stop_cnt_nxt = stop_cnt - 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
        end
      endcase

      if (load) begin
        fifo_pop  = 1'b1;
        state_nxt = START;
        shreg_nxt = head;
        par_nxt   = parity_bit(head_ext, PARITY);
        tx_nxt    = 1'b0;
      end
    end
  end

  // State register; reset aborts any frame and forces the line high.
  always_ff @(posedge srclk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      par_q    <= par_nxt;
      tx_q     <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: four instances with different framing options,
// a scoreboard of pushed words, and a line decoder that rebuilds each frame
// and compares it with the frame format computed from the word.
module tb_frame_serializer;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int DEP = 16;

  function automatic int cfg_par(input int i);
    if (i == 1) return 1;
    if (i == 2) return 2;
    return 0;
  endfunction
  function automatic int cfg_stop(input int i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic int cfg_msb(input int i);
    return (i == 2) ? 1 : 0;
  endfunction
  function automatic int flen(input int i);
    return 1 + DW + ((cfg_par(i) != 0) ? 1 : 0) + cfg_stop(i);
  endfunction

  logic           srclk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_valid, in_ready, bit_tick, tx_out, busy;
  logic [DW-1:0]  in_data [N];
  logic [4:0]     level   [N];

  typedef struct {
    int            id;
    logic [DW-1:0] word;
  } exp_t;
  exp_t sb[$];

  int           nchk = 0;
  int           nerr = 0;
  int           cyc  = 0;
  int           tick_mode [N];
  int           lvl_m     [N];
  int           mon_n     [N];
  logic [31:0]  fr        [N];
  logic         prev_tx   [N];
  logic [N-1:0] tick_d;
  logic         rst_d;
  logic [N-1:0] saw_full = '0;
  int           starts0[$];

  always #5 srclk = ~srclk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    frame_serializer #(
      .DATA_W    (DW),
      .DEPTH     (DEP),
      .PARITY    (cfg_par(g)),
      .STOP_BITS (cfg_stop(g)),
      .MSB_FIRST (cfg_msb(g))
    ) u_dut (
      .srclk    (srclk),
      .reset    (reset),
      .in_valid (in_valid[g]),
      .in_data  (in_data[g]),
      .in_ready (in_ready[g]),
      .bit_tick (bit_tick[g]),
      .tx_out   (tx_out[g]),
      .busy     (busy[g]),
      .level    (level[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Frame as it must appear on the line: start 0, data bits, parity, stops.
  function automatic logic [31:0] exp_frame(input logic [DW-1:0] w, input int i);
    logic [31:0] f;
    int pos;
    int ones;
    f   = '0;
    pos = 1;
    for (int k = 0; k < DW; k++) begin
      f[pos] = w[(cfg_msb(i) != 0) ? (DW - 1 - k) : k];
      pos++;
    end
    if (cfg_par(i) != 0) begin
      ones   = $countones(w);
      f[pos] = (cfg_par(i) == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      pos++;
    end
    for (int s = 0; s < cfg_stop(i); s++) begin
      f[pos] = 1'b1;
      pos++;
    end
    return f;
  endfunction

  function automatic int sb_count(input int g);
    int c;
    c = 0;
    foreach (sb[k]) if (sb[k].id == g) c++;
    return c;
  endfunction

  task automatic finish_frame(input int i);
    int idx;
    idx = -1;
    foreach (sb[k]) if (idx < 0 && sb[k].id == i) idx = k;
    if (idx < 0) begin
      nchk++;
      nerr++;
      $display("FAIL frame[%0d]: got frame %0h, expected no frame", i, fr[i]);
    end else begin
      check($sformatf("frame[%0d] word %0h", i, sb[idx].word), fr[i], exp_frame(sb[idx].word, i));
      sb.delete(idx);
    end
  endtask

  // Remember whether the edge just taken was ticked or a reset edge.
  always @(posedge srclk) begin
    tick_d <= bit_tick;
    rst_d  <= reset;
  end

  // Line decoder and per-cycle checks, evaluated between active edges.
  always @(negedge srclk) begin
    for (int i = 0; i < N; i++) begin
      if (rst_d) begin
        mon_n[i] = 0;
      end else begin
        if (tick_d[i]) begin
          if (mon_n[i] == flen(i)) begin
            finish_frame(i);
            mon_n[i] = 0;
          end
          if (mon_n[i] == 0) begin
            if (tx_out[i] == 1'b0) begin
              fr[i]    = '0;
              mon_n[i] = 1;
              lvl_m[i] = lvl_m[i] - 1;
              if (i == 0) starts0.push_back(cyc);
            end
          end else begin
            fr[i][mon_n[i]] = tx_out[i];
            mon_n[i]++;
          end
        end else begin
          check($sformatf("hold[%0d]", i), tx_out[i], prev_tx[i]);
        end
        check($sformatf("busy[%0d]", i), busy[i], mon_n[i] != 0);
        check($sformatf("level[%0d]", i), level[i], lvl_m[i]);
        check($sformatf("in_ready[%0d]", i), in_ready[i], level[i] != 5'(DEP));
        if (level[i] == 5'(DEP)) saw_full[i] = 1'b1;
      end
      prev_tx[i] = tx_out[i];
    end
  end

  // bit_tick pattern per instance: 0 always, 1 one-in-four, 2 random, 3 off.
  initial begin
    bit_tick = '1;
    forever begin
      @(posedge srclk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        case (tick_mode[i])
          0:       bit_tick[i] = 1'b1;
          1:       bit_tick[i] = ((cyc % 4) == 0);
          2:       bit_tick[i] = 1'($urandom_range(0, 1));
          default: bit_tick[i] = 1'b0;
        endcase
      end
    end
  end

  task automatic push_seq(input int g, input int n, input int rnd,
                          input logic [DW-1:0] base, input int maxgap);
    logic [DW-1:0] d;
    exp_t          e;
    int            t;
    @(posedge srclk);
    #1;
    for (int k = 0; k < n; k++) begin
      d = (rnd != 0) ? DW'($urandom_range(0, 255)) : base + DW'(k);
      in_valid[g] = 1'b1;
      in_data[g]  = d;
      t = 0;
      @(negedge srclk);
      while (!in_ready[g] && t < 2000) begin
        @(negedge srclk);
        t++;
      end
      if (t >= 2000) begin
        fail($sformatf("push[%0d]", g));
        in_valid[g] = 1'b0;
        return;
      end
      @(posedge srclk);
      #1;
      e.id   = g;
      e.word = d;
      sb.push_back(e);
      lvl_m[g] = lvl_m[g] + 1;
      if (maxgap > 0) begin
        in_valid[g] = 1'b0;
        repeat ($urandom_range(0, maxgap)) begin
          @(posedge srclk);
          #1;
        end
      end
    end
    in_valid[g] = 1'b0;
  endtask

  task automatic count_busy(input int g, output int n);
    int t;
    bit seen;
    t    = 0;
    seen = 0;
    n    = 0;
    while (t < 1000) begin
      @(negedge srclk);
      t++;
      if (busy[g]) begin
        seen = 1;
        n++;
      end else if (seen) begin
        break;
      end
    end
    if (t >= 1000) fail($sformatf("busy_count[%0d]", g));
  endtask

  task automatic wait_idle(input int g, input int budget);
    int t;
    t = 0;
    while (t < budget && !(sb_count(g) == 0 && mon_n[g] == 0 && !busy[g])) begin
      @(posedge srclk);
      t++;
    end
    if (t >= budget) fail($sformatf("drain[%0d]", g));
  endtask

  initial begin
    int n;
    int sz;
    int t;
    reset    = 1'b1;
    in_valid = '0;
    for (int i = 0; i < N; i++) begin
      in_data[i]   = '0;
      tick_mode[i] = 0;
    end
    repeat (3) @(posedge srclk);
    @(negedge srclk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst tx_out[%0d]", i), tx_out[i], 1'b1);
      check($sformatf("rst busy[%0d]", i), busy[i], 1'b0);
      check($sformatf("rst level[%0d]", i), level[i], 5'd0);
      check($sformatf("rst in_ready[%0d]", i), in_ready[i], 1'b1);
    end
    @(posedge srclk);
    #1;
    reset = 1'b0;

    // Single 0xA5 frame on the three tick-every-cycle instances.
    push_seq(0, 1, 0, 8'hA5, 0);
    count_busy(0, n);
    check("busy cycles inst0", n, 10);
    wait_idle(0, 200);
    push_seq(1, 1, 0, 8'hA5, 0);
    count_busy(1, n);
    check("busy cycles inst1", n, 11);
    wait_idle(1, 200);
    push_seq(2, 1, 0, 8'hA5, 0);
    count_busy(2, n);
    check("busy cycles inst2", n, 11);
    wait_idle(2, 200);

    // One-in-four ticks, two stop bits.
    tick_mode[3] = 1;
    push_seq(3, 1, 0, 8'h3C, 0);
    count_busy(3, n);
    check("busy cycles inst3", n, 44);
    wait_idle(3, 400);

    // Burst of 20 words into a 16-deep FIFO.
    push_seq(0, 20, 0, 8'h00, 0);
    wait_idle(0, 1000);
    check("burst reached full", saw_full[0], 1'b1);
    sz = starts0.size();
    check("burst frame count", (sz >= 20), 1'b1);
    if (sz >= 20) begin
      for (int k = sz - 19; k < sz; k++)
        check($sformatf("burst gap %0d", k), starts0[k] - starts0[k-1], 10);
    end

    // Push into an empty FIFO on a ticked cycle: pop waits one cycle.
    @(negedge srclk);
    check("empty level before", level[0], 5'd0);
    push_seq(0, 1, 0, 8'h5A, 0);
    @(negedge srclk);
    check("level after push", level[0], 5'd1);
    check("busy after push", busy[0], 1'b0);
    @(negedge srclk);
    check("level after pop", level[0], 5'd0);
    check("busy after pop", busy[0], 1'b1);
    wait_idle(0, 200);

    // Reset during data bit 3 with five words still queued.
    tick_mode[0] = 3;
    push_seq(0, 6, 0, 8'h30, 0);
    tick_mode[0] = 0;
    t = 0;
    while (mon_n[0] != 4 && t < 200) begin
      @(posedge srclk);
      t++;
    end
    if (t >= 200) fail("reach data bit 3");
    check("level at abort", level[0], 5'd5);
    #1;
    reset = 1'b1;
    @(posedge srclk);
    #1;
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) lvl_m[i] = 0;
    @(negedge srclk);
    check("abort tx_out", tx_out[0], 1'b1);
    check("abort busy", busy[0], 1'b0);
    check("abort level", level[0], 5'd0);
    check("abort in_ready", in_ready[0], 1'b1);
    push_seq(0, 1, 0, 8'h55, 0);
    wait_idle(0, 200);

    // Random words, random gaps and random tick pattern on every instance.
    for (int g = 0; g < N; g++) begin
      tick_mode[g] = 2;
      push_seq(g, 25, 1, 8'h00, 3);
      wait_idle(g, 5000);
      tick_mode[g] = 0;
    end
    check("scoreboard empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", nerr);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
- Parametrised successor of the team's byte parallel-to-serial sender.
- Accepts DATA_W-bit words over a valid/ready handshake into an internal FIFO of DEPTH entries.
- Emits each word as a UART-style frame on a single line: start bit 0, data bits, optional parity, STOP_BITS stop bits of 1. Bits are paced by a bit_tick enable.
- Single clock domain on srclk. Sits between the word producer and the off-chip serial line.

Parameters:
- DATA_W, 8: data bits per frame (5..16).
- DEPTH, 16: FIFO entries (power of 2, >=2).
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per frame (1 or 2).
- MSB_FIRST, 0: 0 = LSB sent first, 1 = MSB sent first.

Ports:
- srclk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a word
- in_data  in  DATA_W  word to enqueue
- in_ready  out  1  FIFO can accept (not full)
- bit_tick  in  1  advance serial line one bit-time on this cycle
- tx_out  out  1  serial line, registered
- busy  out  1  frame in progress (state != IDLE)
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: reset, synchronous, active-high; clock srclk.
- Reset values: tx_out=1, busy=0, level=0, in_ready=1, state=IDLE, FIFO pointers 0.
- Reset mid-frame aborts the frame: tx_out returns to 1 on the next edge, and all queued words are discarded.
- Push: word accepted on any edge where in_valid && in_ready. in_ready = (level != DEPTH). No bypass, so a push while full is not possible even if a pop occurs in the same cycle.
- Pop: occurs only in IDLE on a cycle with bit_tick=1 and level>0. The head word is loaded into the shift register, state goes to START, and tx_out=0 from that edge.
- Simultaneous push and pop: level is unchanged. A push into an empty FIFO is not visible to a pop until the following cycle.
- FSM: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
  - Every transition and every bit shift happens only on a bit_tick=1 cycle. When bit_tick=0, all serializer state holds.
  - DATA lasts DATA_W ticks, sending one bit per tick in MSB_FIRST order.
  - PARITY lasts 1 tick. Even parity sends XOR of the data bits; odd parity sends the inverse.
  - STOP lasts STOP_BITS ticks with tx_out=1.
  - At the end of STOP, the FSM returns to IDLE. If level>0 on that same ticked edge, it instead pops immediately and goes to START (back-to-back frames, no idle gap).
- Frame length in ticks: 1 + DATA_W + (PARITY?1:0) + STOP_BITS.
- Bit counter width: $clog2(DATA_W+1). It wraps to 0 on DATA exit. The stop counter is separate.
- tx_out is always 1 in IDLE.
- busy is high from the pop edge through the last stop bit.
- Pointers wrap modulo DEPTH. level is computed from the push/pop count, never from pointer comparison alone.

Decomposition:
- Package frame_ser_pkg holds:
  - typedef enum state_t {IDLE, START, DATA, PAR, STOP}
  - parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2
  - function parity_bit(data, mode)
- Sub-module sync_fifo (DATA_W, DEPTH) provides push/pop/level/full/empty.
- frame_serializer holds only the FSM, shift register and counters.

Test Plan:
- Defaults, bit_tick=1 constant, push 0xA5 -> tx_out after pop edge: 0,1,0,1,0,0,1,0,1,1 then idle 1; busy high exactly 10 cycles.
- PARITY=1 and then PARITY=2, push 0xA5 -> parity bit 0 (even) / 1 (odd) after the 8 data bits; frame 11 ticks. MSB_FIRST=1 -> data bits 1,0,1,0,0,1,0,1.
- bit_tick pulsing 1-in-4, STOP_BITS=2, push 0x3C -> each bit held exactly 4 cycles; 11 ticks = 44 cycles per frame.
- Push 20 words 0x00..0x13 back-to-back with DEPTH=16, bit_tick=1 -> in_ready drops when level=16; no word lost or duplicated; frames contiguous with no idle gap; serialized order 0x00..0x13.
- Assert reset during DATA bit 3 of a frame with 5 words queued -> next edge: tx_out=1, busy=0, level=0, in_ready=1; a subsequent push of 0x55 is framed correctly.
- Push into an empty FIFO on the same cycle as bit_tick=1 -> no pop that cycle; pop on the next ticked cycle; level goes 0->1->0.
